// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: round-robin, packet-atomic arbiter that merges N_SRC
// 32-bit packet sources onto one AXI-Stream master link. The output is a
// single register stage. TDEST is taken from the first word of each packet.
// Packets longer than MAX_BEATS are cut short, and their tail is drained.
module axis_pkt_arbiter #(
    parameter int N_SRC     = 4,
    parameter int MAX_BEATS = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SRC-1:0]     src_valid,
    output logic [N_SRC-1:0]     src_ready,
    input  logic [N_SRC*32-1:0]  src_data,
    input  logic [N_SRC-1:0]     src_last,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [31:0]          m_tdata,
    output logic                 m_tlast,
    output logic [7:0]           m_tdest,
    output logic [3:0]           m_tuser,
    output logic [N_SRC-1:0]     grant,
    output logic                 err_overrun
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t                  state;
    logic [IW-1:0]           g;          // index of the current owner
    logic [IW-1:0]           rr_ptr;     // highest-priority index for the next grant
    logic [IW-1:0]           nxt;
    logic [IW-1:0]           g_inc;
    logic                    found;
    int                      idx;
    logic [15:0]             beat_cnt;
    logic [7:0]              dest_q;
    logic [N_SRC-1:0][31:0]  data_v;
    logic [31:0]             sel_data;
    logic                    sel_last;
    logic                    out_free;
    logic                    beat;
    logic                    drain_beat;
    logic                    at_max;

    assign data_v     = src_data;
    assign sel_data   = data_v[g];
    assign sel_last   = src_last[g];
    assign out_free   = !m_tvalid || m_tready;
    assign beat       = (state == XFER) && out_free && src_valid[g];
    assign drain_beat = (state == DRAIN) && src_valid[g];
    assign at_max     = ({1'b0, beat_cnt} + 17'd1) == 17'(MAX_BEATS);
    assign g_inc      = (g == IW'(N_SRC - 1)) ? '0 : g + 1'b1;

    // Pick the first valid source at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        idx   = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % N_SRC;
            if (!found && src_valid[idx]) begin
                found = 1'b1;
                nxt   = IW'(idx);
            end
        end
    end

    // Only the owner is ever ready. While draining, beats are swallowed freely.
    always_comb begin
        src_ready = '0;
        if ((state == XFER && out_free) || state == DRAIN)
            src_ready = grant;
    end

    // FSM, output register, framing, beat counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            g           <= '0;
            rr_ptr      <= '0;
            grant       <= '0;
            beat_cnt    <= '0;
            dest_q      <= '0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tlast     <= 1'b0;
            m_tdest     <= '0;
            m_tuser     <= '0;
            err_overrun <= 1'b0;
        end else begin
            err_overrun <= 1'b0;

            // Load a new beat, or retire the held one once it has been taken.
            if (beat) begin
                m_tvalid <= 1'b1;
                m_tdata  <= sel_data;
                m_tuser  <= {3'b000, beat_cnt == 16'd0};
                m_tdest  <= (beat_cnt == 16'd0) ? sel_data[31:24] : dest_q;
                m_tlast  <= sel_last || at_max;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        g     <= nxt;
                        grant <= N_SRC'(1) << nxt;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        if (beat_cnt == 16'd0)
                            dest_q <= sel_data[31:24];
                        if (sel_last) begin
                            beat_cnt <= '0;
                            rr_ptr   <= g_inc;
                            grant    <= '0;
                            state    <= IDLE;
                        end else if (at_max) begin
                            beat_cnt    <= '0;
                            err_overrun <= 1'b1;
                            state       <= DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_beat && sel_last) begin
                        rr_ptr <= g_inc;
                        grant  <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
